snake_input_conditioner: RTL and testbench
==========================================

Name: snake_input_conditioner

Overview:
Front-end stage feeding the snake game core. It synchronises and debounces the two raw active-low push-buttons and converts each clean press into a single held turn request (right/left) with a valid/ack handshake. It also generates the one-cycle move_tick strobe that paces the game core, with a period set by the core's current delay value. This replaces the free-running counter and ad-hoc pressed/applied flags with a clean upstream interface.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a key level change (10 ms at 50 MHz).
TICK_UNIT, 20000, clock cycles per unit of delay.
DELAY_W, 5, width of the delay input.

Ports:
clockInp  in  1  system clock (only clock).
resetInp_n  in  1  reset, asynchronous assert, active-low.
KEY  in  2  raw buttons, active-low; KEY[0] = turn right, KEY[1] = turn left.
delay  in  DELAY_W  move period in TICK_UNIT cycles; 0 treated as 1.
move_tick  out  1  one-cycle strobe at each move boundary.
turn_valid  out  1  a turn request is pending.
turn_dir  out  1  0 = right, 1 = left; stable while turn_valid=1.
turn_ack  in  1  core consumed the pending request.
key_state  out  2  debounced key levels, active-low.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: move_tick=0, turn_valid=0, turn_dir=0, key_state=2'b11, synchroniser flops=1, debounce counters=0, tick counter=0.
- Synchroniser: 2 flops per key. The raw KEY is never used directly.
- Debounce, per key:
  - Counter resets to 0 whenever the synchronised sample equals key_state.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1 it loads the sample into key_state and clears.
  - Latency from a KEY edge to the key_state change is 2 + DEBOUNCE_CYCLES cycles.
- Press event: key_state[k] goes 1->0. Releases produce no event.
- Request register (single entry):
  - On a press event with turn_valid=0, or with turn_valid=1 and turn_ack=1, the next cycle has turn_valid=1 and turn_dir=k.
  - A press while a request is pending and not acked in the same cycle is dropped. This gives at most one turn per move.
  - turn_ack with turn_valid=1 and no press event clears turn_valid on the next cycle.
  - turn_ack while turn_valid=0 is ignored.
  - Press events on both keys in the same cycle: right (dir 0) wins, left is dropped.
- Tick generator:
  - Terminal count T = max(delay,1)*TICK_UNIT - 1. The counter width holds (2^DELAY_W - 1)*TICK_UNIT.
  - When counter >= T: move_tick=1 for that cycle and the counter goes to 0. Otherwise the counter increments.
  - delay is sampled every cycle. Lowering delay below the current count forces a tick on the next cycle, with no long wrap.
  - Tick period is exactly T+1 cycles when delay is constant.
- Reset asserted mid-operation: all state returns to reset values immediately. The pending request is lost. The first tick after release comes T+1 cycles after the first active edge.

Decomposition:
- Package snake_pkg holds:
  - TURN_RIGHT=1'b0 and TURN_LEFT=1'b1.
  - Default DEBOUNCE_CYCLES and TICK_UNIT.
  - MAX_DELAY=20 and MIN_DELAY=10 (the game's speed range).
- Sub-module snake_key_debounce: synchroniser, counter and key_state for one key, plus a one-cycle press pulse output. It is instantiated twice. The request register and tick generator live in the top.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, TICK_UNIT=3.
1. Bounce rejection and clean press:
   - KEY[0] low for 3 cycles, then high -> key_state stays 11, turn_valid stays 0.
   - KEY[0] held low -> key_state[0]=0 at cycle 6 after the edge; turn_valid=1, turn_dir=0 at cycle 7.
2. Drop while pending: with the right request pending and no ack, a clean KEY[1] press -> turn_dir stays 0. turn_ack for one cycle -> turn_valid=0 on the next cycle, and the KEY[1] press is not replayed.
3. Ack and press in the same cycle: request pending, turn_ack=1 in the cycle of a KEY[1] press event -> the next cycle has turn_valid=1, turn_dir=1.
4. Simultaneous press: both KEY edges in the same cycle -> exactly one request, turn_dir=0. Holding both keys produces no further request after the ack.
5. Tick timing:
   - delay=2 -> move_tick every 6 cycles.
   - delay=0 -> every 3 cycles.
   - delay changed 5->1 while counter=7 -> move_tick on the next cycle, then every 3.
6. Async reset: assert resetInp_n=0 mid-period with a request pending -> turn_valid=0 and move_tick=0 before the next clock edge. After release with delay=2, the first tick comes 6 cycles after the first active edge.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants for the snake game front end: turn encodings, default
// timing parameters, the game's speed range and the tick terminal-count helper.
package snake_pkg;

   localparam logic TURN_RIGHT = 1'b0;
   localparam logic TURN_LEFT  = 1'b1;

   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_TICK_UNIT       = 20000;

   localparam int MAX_DELAY = 20;
   localparam int MIN_DELAY = 10;

   // A delay of zero behaves as one unit so the game never stalls.
   function automatic int tick_terminal(input int delay_units, input int unit);
      return ((delay_units < 1) ? 1 : delay_units) * unit - 1;
   endfunction

endpackage

// File: rtl/snake_key_debounce.sv
// One push-button channel: two-flop synchroniser, stability counter,
// debounced level and a one-cycle pulse on each accepted press (1 -> 0).
module snake_key_debounce
   import snake_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clockInp,
   input  logic resetInp_n,
   input  logic key_raw,
   output logic key_state,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             key_sync;
   logic [CNT_W-1:0] cnt;

   assign key_sync = sync_q[1];

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clockInp or negedge resetInp_n) begin
      if (!resetInp_n) begin
         sync_q    <= 2'b11;
         key_state <= 1'b1;
         cnt       <= '0;
         press     <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], key_raw};
         press  <= 1'b0;
         if (key_sync == key_state) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            key_state <= key_sync;
            cnt       <= '0;
            // Only a high-to-low transition of the debounced level is a press.
            press     <= ~key_sync;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/snake_input_conditioner.sv
// Game-core front end: debounced keys become single held turn requests with a
// valid/ack handshake, plus the move_tick strobe paced by the core's delay.
module snake_input_conditioner
   import snake_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int TICK_UNIT       = DEF_TICK_UNIT,
   parameter int DELAY_W         = 5
) (
   input  logic               clockInp,
   input  logic               resetInp_n,
   input  logic [1:0]         KEY,
   input  logic [DELAY_W-1:0] delay,
   output logic               move_tick,
   output logic               turn_valid,
   output logic               turn_dir,
   input  logic               turn_ack,
   output logic [1:0]         key_state
);

   localparam int MAX_COUNT = (2**DELAY_W - 1) * TICK_UNIT;
   localparam int TCNT_W    = $clog2(MAX_COUNT + 1);

   logic [1:0] press;

   for (genvar k = 0; k < 2; k++) begin : g_key
      snake_key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clockInp  (clockInp),
         .resetInp_n(resetInp_n),
         .key_raw   (KEY[k]),
         .key_state (key_state[k]),
         .press     (press[k])
      );
   end

   logic turn_valid_d;
   logic turn_dir_d;
   logic accept;

   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      turn_valid_d = turn_valid;
      turn_dir_d   = turn_dir;
      accept       = (press != 2'b00) && (!turn_valid || turn_ack);
      if (accept) begin
         turn_valid_d = 1'b1;
         // Right wins when both keys land in the same cycle.
         turn_dir_d   = press[0] ? TURN_RIGHT : TURN_LEFT;
      end else if (turn_valid && turn_ack) begin
         turn_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clockInp or negedge resetInp_n) begin
      if (!resetInp_n) begin
         turn_valid <= 1'b0;
         turn_dir   <= TURN_RIGHT;
      end else begin
         turn_valid <= turn_valid_d;
         turn_dir   <= turn_dir_d;
      end
   end

   logic [TCNT_W-1:0] tick_cnt;
   logic [TCNT_W-1:0] tick_term;

   assign tick_term = TCNT_W'(tick_terminal(int'(delay), TICK_UNIT));

   // >= rather than == so a lowered delay ends the period at once instead of wrapping.
   always_ff @(posedge clockInp or negedge resetInp_n) begin
      if (!resetInp_n) begin
         tick_cnt  <= '0;
         move_tick <= 1'b0;
      end else if (tick_cnt >= tick_term) begin
         tick_cnt  <= '0;
         move_tick <= 1'b1;
      end else begin
         tick_cnt  <= tick_cnt + TCNT_W'(1);
         move_tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_snake_input_conditioner.sv
// Scoreboard bench: stimulus pushes expected requests/ticks with their cycle
// numbers; a negedge monitor pops and compares whenever the DUT presents one.
module tb_snake_input_conditioner;
   import snake_pkg::*;

   typedef struct {
      int unsigned cyc;
      logic        dir;
   } req_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] key = 2'b11;
   logic [4:0] delay = 5'd2;
   logic       turn_ack = 1'b0;
   logic       move_tick;
   logic       turn_valid;
   logic       turn_dir;
   logic [1:0] key_state;

   int unsigned cyc = 0;
   int          n_total = 0;
   int          n_bad = 0;
   req_t        req_q[$];
   int unsigned tick_q[$];
   bit          tick_en = 1'b0;
   logic        prev_valid = 1'b0;
   logic        prev_ack = 1'b0;
   logic        prev_dir = 1'b0;

   snake_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .TICK_UNIT      (3),
      .DELAY_W        (5)
   ) dut (
      .clockInp  (clk),
      .resetInp_n(rst_n),
      .KEY       (key),
      .delay     (delay),
      .move_tick (move_tick),
      .turn_valid(turn_valid),
      .turn_dir  (turn_dir),
      .turn_ack  (turn_ack),
      .key_state (key_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int unsigned c);
      while (cyc < c) step();
   endtask

   task automatic sync_tick(output int unsigned t);
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (move_tick) seen = 1'b1;
      end
      check("tick_sync_found", 32'(seen), 32'd1);
      t = cyc;
   endtask

   // Monitor: a new request is a valid cycle not continuing an un-acked one.
   always @(negedge clk) begin
      req_t        e;
      int unsigned exp_t;
      if (turn_valid && (!prev_valid || prev_ack)) begin
         if (req_q.size() > 0) begin
            e = req_q.pop_front();
            check("req_cycle", cyc, e.cyc);
            check("req_dir", 32'(turn_dir), 32'(e.dir));
         end else begin
            check("req_unexpected_cycle", cyc, 32'hFFFF_FFFF);
         end
      end else if (turn_valid && prev_valid) begin
         check("req_dir_stable", 32'(turn_dir), 32'(prev_dir));
      end
      if (tick_en && move_tick) begin
         exp_t = (tick_q.size() > 0) ? tick_q.pop_front() : 32'hFFFF_FFFF;
         check("tick_cycle", cyc, exp_t);
      end
      prev_valid = turn_valid;
      prev_ack   = turn_ack;
      prev_dir   = turn_dir;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned c, d, t0;

      step(3);
      check("rst_move_tick", 32'(move_tick), 32'd0);
      check("rst_turn_valid", 32'(turn_valid), 32'd0);
      check("rst_turn_dir", 32'(turn_dir), 32'd0);
      check("rst_key_state", 32'(key_state), 32'd3);
      rst_n = 1'b1;
      step(2);

      // 1a: a 3-cycle low glitch on KEY[0] is rejected
      key = 2'b10;
      step(3);
      key = 2'b11;
      step(10);
      check("bounce_key_state", 32'(key_state), 32'd3);
      check("bounce_turn_valid", 32'(turn_valid), 32'd0);

      // 1b: clean right press, key_state at +6, request at +7
      c = cyc;
      key = 2'b10;
      req_q.push_back('{cyc: c + 7, dir: TURN_RIGHT});
      step(5);
      check("press_key_state_c5", 32'(key_state), 32'd3);
      step();
      check("press_key_state_c6", 32'(key_state), 32'd2);
      step();
      check("press_valid_c7", 32'(turn_valid), 32'd1);

      // 2: left press while right is pending and un-acked is dropped
      key = 2'b00;
      step(6);
      check("drop_key_state", 32'(key_state), 32'd0);
      step(2);
      check("drop_valid", 32'(turn_valid), 32'd1);
      check("drop_dir", 32'(turn_dir), 32'(TURN_RIGHT));
      turn_ack = 1'b1;
      step();
      turn_ack = 1'b0;
      check("ack_clears", 32'(turn_valid), 32'd0);
      key = 2'b11;
      step(10);
      check("no_replay_valid", 32'(turn_valid), 32'd0);
      check("release_key_state", 32'(key_state), 32'd3);

      // 3: ack in the same cycle as a left press event
      c = cyc;
      key = 2'b10;
      req_q.push_back('{cyc: c + 7, dir: TURN_RIGHT});
      step(8);
      d = cyc;
      key = 2'b00;
      req_q.push_back('{cyc: d + 7, dir: TURN_LEFT});
      step(6);
      turn_ack = 1'b1;
      step();
      turn_ack = 1'b0;
      check("ack_press_valid", 32'(turn_valid), 32'd1);
      check("ack_press_dir", 32'(turn_dir), 32'(TURN_LEFT));
      turn_ack = 1'b1;
      step();
      turn_ack = 1'b0;
      key = 2'b11;
      step(10);

      // 4: both keys pressed together, right wins, nothing after the ack
      c = cyc;
      key = 2'b00;
      req_q.push_back('{cyc: c + 7, dir: TURN_RIGHT});
      step(9);
      turn_ack = 1'b1;
      step();
      turn_ack = 1'b0;
      step(10);
      check("both_held_no_req", 32'(turn_valid), 32'd0);
      key = 2'b11;
      step(10);

      // 5a: delay=2 -> period 6
      delay = 5'd2;
      sync_tick(t0);
      step();
      for (int i = 1; i <= 3; i++) tick_q.push_back(t0 + 6 * i);
      tick_en = 1'b1;
      wait_until(t0 + 19);
      tick_en = 1'b0;

      // 5b: delay=0 behaves as 1 -> period 3
      delay = 5'd0;
      sync_tick(t0);
      step();
      for (int i = 1; i <= 3; i++) tick_q.push_back(t0 + 3 * i);
      tick_en = 1'b1;
      wait_until(t0 + 10);
      tick_en = 1'b0;

      // 5c: delay 5 -> 1 while the counter holds 7 forces a tick next cycle
      delay = 5'd5;
      sync_tick(t0);
      step();
      tick_q.push_back(t0 + 8);
      tick_q.push_back(t0 + 11);
      tick_q.push_back(t0 + 14);
      tick_en = 1'b1;
      wait_until(t0 + 7);
      delay = 5'd1;
      wait_until(t0 + 15);
      tick_en = 1'b0;

      // 6: async reset with a request pending, then first tick timing
      c = cyc;
      key = 2'b10;
      delay = 5'd2;
      req_q.push_back('{cyc: c + 7, dir: TURN_RIGHT});
      step(9);
      check("pre_reset_valid", 32'(turn_valid), 32'd1);
      key = 2'b11;
      rst_n = 1'b0;
      #2;
      check("async_rst_valid", 32'(turn_valid), 32'd0);
      check("async_rst_tick", 32'(move_tick), 32'd0);
      check("async_rst_key_state", 32'(key_state), 32'd3);
      step(2);
      rst_n = 1'b1;
      c = cyc;
      tick_q.push_back(c + 6);
      tick_en = 1'b1;
      wait_until(c + 7);
      tick_en = 1'b0;
      check("post_reset_valid", 32'(turn_valid), 32'd0);

      step(3);
      check("req_q_drained", 32'(req_q.size()), 32'd0);
      check("tick_q_drained", 32'(tick_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
